// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DEF_TIMEOUT = 255;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Turns the core's single-cycle data memory command into a req/ack bus
// transaction, stalling the core until data or write completion is available.
//
// state | meaning
// IDLE  | waiting for core_mem_en; stall follows core_mem_en
// BUSY  | bus_req held until ack or timeout
// DONE  | result presented to core for one cycle, stall released
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_mem_en,
  input  logic        core_mem_wr,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_wdata,
  output logic [31:0] core_mem_rdata,
  output logic        core_stall,
  output logic        core_err,
  output logic        err_sticky,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [31:2]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_wr;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic            r_sticky;
  logic [TO_W-1:0] r_cnt;

  state_t          w_next;
  logic            w_done_set;
  logic            w_done_err;
  logic [31:0]     w_done_rdata;

  always_comb begin
    w_next       = r_state;
    core_stall   = 1'b0;
    core_err     = 1'b0;
    bus_req      = 1'b0;
    w_done_set   = 1'b0;
    w_done_err   = 1'b0;
    w_done_rdata = '0;
    case (r_state)
      IDLE: begin
        core_stall = core_mem_en;
        if (core_mem_en) begin
          if (is_misaligned(core_mem_addr[1:0])) begin
            w_next     = DONE;
            w_done_set = 1'b1;
            w_done_err = 1'b1;
          end else begin
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        bus_req    = 1'b1;
        core_stall = 1'b1;
        // An ack in the final allowed cycle still completes normally.
        if (bus_ack) begin
          w_next       = DONE;
          w_done_set   = 1'b1;
          w_done_err   = bus_err;
          w_done_rdata = r_wr ? 32'h0 : bus_rdata;
        end else if (r_cnt == TO_LAST) begin
          w_next     = DONE;
          w_done_set = 1'b1;
          w_done_err = 1'b1;
        end
      end
      DONE: begin
        core_err = r_err;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && core_mem_en) begin
        r_addr  <= core_mem_addr[31:2];
        r_wdata <= core_mem_wdata;
        r_wr    <= core_mem_wr;
      end
      if (r_state == BUSY) r_cnt <= r_cnt + 1'b1;
      else                 r_cnt <= '0;
      if (w_done_set) begin
        r_rdata <= w_done_rdata;
        r_err   <= w_done_err;
        if (w_done_err) r_sticky <= 1'b1;
      end
    end
  end

  assign core_mem_rdata = r_rdata;
  assign err_sticky     = r_sticky;
  assign bus_we         = r_wr;
  assign bus_addr       = {r_addr, 2'b00};
  assign bus_wdata      = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: table of accesses with a bus responder
// and a result scoreboard, plus hand sequences for late ack and mid-access reset.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_mem_en, core_mem_wr;
  logic [31:0] core_mem_addr, core_mem_wdata, core_mem_rdata;
  logic        core_stall, core_err, err_sticky;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .core_mem_en(core_mem_en), .core_mem_wr(core_mem_wr),
    .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
    .core_mem_rdata(core_mem_rdata), .core_stall(core_stall),
    .core_err(core_err), .err_sticky(err_sticky),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] brdata;
    logic        berr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_stall;
    int          exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic sticky_exp = 1'b0;
  vec_t tbl[9];
  vec_t post;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    int   stallc = 0;
    int   reqc = 0;
    bit   done = 0;
    bit   stable = 1;
    bit   spurious = 0;
    exp_t e, got;
    @(posedge clk); #1;
    core_mem_en    = 1'b1;
    core_mem_wr    = v.wr;
    core_mem_addr  = v.addr;
    core_mem_wdata = v.wdata;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    sticky_exp = sticky_exp | v.exp_err;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (bus_req) begin
        reqc++;
        if (reqc - 1 == v.waits) begin
          bus_ack = 1'b1; bus_rdata = v.brdata; bus_err = v.berr;
        end else begin
          bus_ack = 1'b0; bus_rdata = 32'hBAD0_0000 | 32'(reqc); bus_err = 1'b1;
        end
      end else begin
        // Garbage outside BUSY must be ignored.
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF; bus_err = 1'b1;
      end
      @(negedge clk);
      if (core_stall) stallc++;
      if (bus_req && (bus_addr !== {v.addr[31:2], 2'b00} || bus_we !== v.wr ||
                      bus_wdata !== v.wdata)) stable = 0;
      if (core_mem_en && !core_stall) begin
        done = 1;
        chk({tag, " req_in_done"}, {31'b0, bus_req}, 32'h0);
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL %s scoreboard: result seen with empty queue", tag);
        end else begin
          got = sb.pop_front();
          chk({tag, " rdata"}, core_mem_rdata, got.rdata);
          chk({tag, " err"}, {31'b0, core_err}, {31'b0, got.err});
        end
        chk({tag, " sticky"}, {31'b0, err_sticky}, {31'b0, sticky_exp});
      end else begin
        if (core_err) spurious = 1;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s completion: no DONE within 40 cycles, required one", tag);
      void'(sb.pop_back());
    end
    chk({tag, " stall_cycles"}, 32'(stallc), 32'(v.exp_stall));
    chk({tag, " req_cycles"}, 32'(reqc), 32'(v.exp_req));
    chk({tag, " bus_stable"}, {31'b0, stable}, 32'h1);
    chk({tag, " no_early_err"}, {31'b0, spurious}, 32'h0);
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  initial begin
    int  reqc;
    bit  found;
    rst = 1'b1; core_mem_en = 1'b0; core_mem_wr = 1'b0;
    core_mem_addr = '0; core_mem_wdata = '0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;

    //           wr    addr          wdata         waits brdata        berr  exp_rdata     err   stall req
    tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 1};
    tbl[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 3,  32'h5555_5555, 1'b0, 32'h0,         1'b0, 5, 4};
    tbl[2] = '{1'b0, 32'h0000_0003, 32'h0,         0,  32'h0,         1'b0, 32'h0,         1'b1, 1, 0};
    tbl[3] = '{1'b0, 32'h0000_0040, 32'h0,         0,  32'hA5A5_0040, 1'b0, 32'hA5A5_0040, 1'b0, 2, 1};
    tbl[4] = '{1'b0, 32'h0000_0044, 32'h0,         0,  32'h5A5A_0044, 1'b0, 32'h5A5A_0044, 1'b0, 2, 1};
    tbl[5] = '{1'b0, 32'h0000_0080, 32'h0,         1,  32'h1111_2222, 1'b1, 32'h1111_2222, 1'b1, 3, 2};
    tbl[6] = '{1'b1, 32'h0000_0002, 32'hAAAA_BBBB, 0,  32'h0,         1'b0, 32'h0,         1'b1, 1, 0};
    tbl[7] = '{1'b0, 32'h0000_0100, 32'h0,         3,  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 5, 4};
    tbl[8] = '{1'b0, 32'h0000_0200, 32'h0,         99, 32'h0,         1'b0, 32'h0,         1'b1, 5, 4};
    post   = '{1'b0, 32'h0000_0304, 32'h0,         0,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 2, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdata",  core_mem_rdata, 32'h0);
    chk("rst stall",  {31'b0, core_stall}, 32'h0);
    chk("rst err",    {31'b0, core_err}, 32'h0);
    chk("rst sticky", {31'b0, err_sticky}, 32'h0);
    chk("rst req",    {31'b0, bus_req}, 32'h0);
    chk("rst we",     {31'b0, bus_we}, 32'h0);
    chk("rst addr",   bus_addr, 32'h0);
    chk("rst wdata",  bus_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("v%0d", i));

    // Late ack after the timeout must be ignored.
    @(posedge clk); #1;
    core_mem_en = 1'b0;
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("late req",   {31'b0, bus_req}, 32'h0);
    chk("late stall", {31'b0, core_stall}, 32'h0);
    chk("late err",   {31'b0, core_err}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late rdata", core_mem_rdata, 32'h0);
    chk("late err2",  {31'b0, core_err}, 32'h0);
    chk("late req2",  {31'b0, bus_req}, 32'h0);
    bus_ack = 1'b0; bus_err = 1'b0;

    // Reset during the second BUSY cycle of a long read.
    @(posedge clk); #1;
    core_mem_en = 1'b1; core_mem_wr = 1'b0;
    core_mem_addr = 32'h0000_0300; core_mem_wdata = 32'h0;
    reqc = 0; found = 0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      if (bus_req) begin
        reqc++;
        if (reqc == 2) found = 1;
      end
      if (!found) begin
        @(posedge clk); #1;
      end
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL rstmid busy: never reached second BUSY cycle, required it");
    end
    chk("rstmid sticky_before", {31'b0, err_sticky}, 32'h1);
    rst = 1'b1; core_mem_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sticky_exp = 1'b0;
    @(negedge clk);
    chk("rstmid req",    {31'b0, bus_req}, 32'h0);
    chk("rstmid stall",  {31'b0, core_stall}, 32'h0);
    chk("rstmid sticky", {31'b0, err_sticky}, 32'h0);
    chk("rstmid rdata",  core_mem_rdata, 32'h0);

    run(post, "post_rst");
    @(posedge clk); #1;
    core_mem_en = 1'b0;
    @(negedge clk);
    chk("sb empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
